// File: rtl/la_capture_core.sv
// 8-bit logic-analyzer capture engine: synchronized probe sampling at a divided rate into a
// circular buffer, masked-pattern trigger with pre-trigger history, oldest-first readout.
module la_capture_core #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            probe_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DIV_W-1:0]      div,
  input  logic [7:0]            trig_mask,
  input  logic [7:0]            trig_value,
  input  logic [DEPTH_LOG2-1:0] pretrig,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            sync1_q, sync2_q;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] start_ptr_q, start_ptr_d;
  logic [DEPTH_LOG2-1:0] pre_cnt_q, pre_cnt_d;
  logic [DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
  logic                  trig_q, trig_d;
  logic [7:0]            rd_data_q;
  logic [7:0]            mem [DEPTH];

  logic                  tick, match, we, arm_ok;
  logic [DEPTH_LOG2-1:0] pt, post_init, rd_idx;

  // pretrig is DEPTH_LOG2 bits wide, so it can never exceed DEPTH-1 and the clamp is identity.
  assign pt        = pretrig;
  assign post_init = ~pt;  // DEPTH - pt - 1 within DEPTH_LOG2 bits
  assign tick      = (cnt_q == div);
  assign match     = ((sync2_q ^ trig_value) & trig_mask) == 8'h00;
  assign arm_ok    = arm && !abort && (state_q == IDLE || state_q == DONE);
  assign rd_idx    = start_ptr_q + rd_addr;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (arm_ok || abort) cnt_d = '0;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_d      = trig_q;
    we          = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            wr_ptr_d  = '0;
            pre_cnt_d = '0;
            trig_d    = 1'b0;
            state_d   = (pt != '0) ? PRE : WAIT_TRIG;
          end
        end
        PRE: begin
          if (tick) begin
            we        = 1'b1;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            pre_cnt_d = pre_cnt_q + 1'b1;
            if (pre_cnt_q + 1'b1 == pt) state_d = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (tick) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (match) begin
              trig_d      = 1'b1;
              start_ptr_d = wr_ptr_q - pt;
              post_cnt_d  = post_init;
              state_d     = (post_init == '0) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (tick) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == 1) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= probe_in;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_q      <= trig_d;
      rd_data_q   <= mem[rd_idx];
    end
  end

  // Buffer kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= sync2_q;
  end

  assign rd_data   = rd_data_q;
  assign busy      = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign triggered = trig_q;
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core (DEPTH 16): directed scenarios plus random captures checked
// against a tick-sample list model built from a per-cycle log of probe values.
module tb_la_capture_core;
  localparam int DL = 4;
  localparam int DW = 16;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst, arm, abort;
  logic [7:0]    probe_in, trig_mask, trig_value, rd_data;
  logic [DW-1:0] div;
  logic [DL-1:0] pretrig, rd_addr;
  logic          busy, triggered, done;

  la_capture_core #(.DEPTH_LOG2(DL), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .probe_in(probe_in), .arm(arm), .abort(abort), .div(div),
    .trig_mask(trig_mask), .trig_value(trig_value), .pretrig(pretrig), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         pmode = 0;  // 0 count, 1 random, 2 count mod 8, 3 constant zero
  int         arm_cyc;
  int         exp_cf;
  logic [7:0] plog [0:65535];
  logic [7:0] exp_buf [D];
  logic [7:0] rd_buf [D];

  // One clock: outputs are examined #1 after the edge, then the next probe value is driven.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (pmode)
      0:       probe_in = cyc[7:0];
      1:       probe_in = 8'($urandom);
      2:       probe_in = {5'b0, cyc[2:0]};
      default: probe_in = 8'h00;
    endcase
    plog[cyc] = probe_in;
  endtask

  task automatic cfg(input int d, input int pt, input logic [7:0] m, input logic [7:0] v);
    div = DW'(d); pretrig = DL'(pt); trig_mask = m; trig_value = v;
  endtask

  task automatic do_arm();
    arm = 1'b1; arm_cyc = cyc;
    step();
    arm = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin dc = cyc; break; end
      step();
    end
  endtask

  task automatic readback();
    for (int i = 0; i < D; i++) begin
      rd_addr = DL'(i);
      step();
      rd_buf[i] = rd_data;
    end
  endtask

  // Ticks fall on cycles a+1+d+k*(d+1); the synchronized sample on cycle c is the probe
  // value of cycle c-2. The trigger is the first matching tick at index >= pt, and the
  // buffer holds tick samples j-pt .. j+D-pt-1. exp_cf = cycle of the last write, or -1.
  task automatic model(input int a, input int d, input int pt, input logic [7:0] m,
                       input logic [7:0] v);
    logic [7:0] ts[$];
    int j;
    j = -1; exp_cf = -1;
    for (int k = 0; k < 600; k++) begin
      int c;
      c = a + 1 + d + k * (d + 1);
      if (c - 2 > cyc) break;
      ts.push_back(plog[c-2]);
      if (j < 0 && k >= pt && ((plog[c-2] ^ v) & m) == 8'h00) j = k;
      if (j >= 0 && k == j + D - pt - 1) begin exp_cf = c; break; end
    end
    for (int i = 0; i < D; i++) exp_buf[i] = (exp_cf >= 0) ? ts[j-pt+i] : 8'hxx;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_addr = '0;
    cfg(0, 0, 8'h00, 8'h00);
    repeat (3) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL reset_trig: got %b want 0", triggered); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd: got %h want 00", rd_data); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_free_run();
    int dc;
    pmode = 0; cfg(0, 0, 8'h00, 8'h00);
    step();
    do_arm();
    wait_done(dc);
    model(arm_cyc, 0, 0, 8'h00, 8'h00);
    total++; if (dc !== arm_cyc + 17) begin bad++; $display("FAIL free_done_cyc: got %0d want %0d", dc, arm_cyc + 17); end
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL free_trig: got %b want 1", triggered); end
    readback();
    for (int i = 0; i < D; i++) begin
      total++;
      if (rd_buf[i] !== 8'(plog[arm_cyc-1] + i)) begin
        bad++; $display("FAIL free_rd[%0d]: got %h want %h", i, rd_buf[i], 8'(plog[arm_cyc-1] + i));
      end
    end
  endtask

  task automatic test_pretrig_wrap();
    int dc;
    pmode = 0; cfg(0, 5, 8'hFF, 8'h20);
    while (probe_in !== 8'h05) step();
    do_arm();
    wait_done(dc);
    model(arm_cyc, 0, 5, 8'hFF, 8'h20);
    total++; if (dc < 0 || dc !== exp_cf + 1) begin bad++; $display("FAIL wrap_done_cyc: got %0d want %0d", dc, exp_cf + 1); end
    readback();
    total++; if (rd_buf[5] !== 8'h20) begin bad++; $display("FAIL wrap_rd5: got %h want 20", rd_buf[5]); end
    total++; if (rd_buf[0] !== 8'h1B) begin bad++; $display("FAIL wrap_rd0: got %h want 1b", rd_buf[0]); end
    total++; if (rd_buf[15] !== 8'h2A) begin bad++; $display("FAIL wrap_rd15: got %h want 2a", rd_buf[15]); end
    for (int i = 0; i < D; i++) begin
      total++;
      if (rd_buf[i] !== exp_buf[i]) begin bad++; $display("FAIL wrap_model[%0d]: got %h want %h", i, rd_buf[i], exp_buf[i]); end
    end
  endtask

  task automatic test_divider();
    int nb;
    pmode = 0; cfg(3, 0, 8'h00, 8'h00);
    step();
    do_arm();
    nb = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      if (busy) nb++;
      step();
    end
    model(arm_cyc, 3, 0, 8'h00, 8'h00);
    total++; if (nb !== 64) begin bad++; $display("FAIL div_busy_len: got %0d want 64", nb); end
    readback();
    for (int i = 0; i < D - 1; i++) begin
      total++;
      if (8'(rd_buf[i+1] - rd_buf[i]) !== 8'd4) begin
        bad++; $display("FAIL div_step[%0d]: got %h,%h want step 4", i, rd_buf[i], rd_buf[i+1]);
      end
    end
    for (int i = 0; i < D; i++) begin
      total++;
      if (rd_buf[i] !== exp_buf[i]) begin bad++; $display("FAIL div_model[%0d]: got %h want %h", i, rd_buf[i], exp_buf[i]); end
    end
  endtask

  task automatic test_pre_ignored();
    int dc;
    pmode = 2; cfg(0, 4, 8'hFF, 8'h01);
    step();
    while (probe_in !== 8'h01) step();
    do_arm();
    wait_done(dc);
    model(arm_cyc, 0, 4, 8'hFF, 8'h01);
    total++; if (dc < 0 || dc !== exp_cf + 1) begin bad++; $display("FAIL preign_done_cyc: got %0d want %0d", dc, exp_cf + 1); end
    readback();
    total++; if (rd_buf[4] !== 8'h01) begin bad++; $display("FAIL preign_rd4: got %h want 01", rd_buf[4]); end
    total++; if (rd_buf[3] !== 8'h00) begin bad++; $display("FAIL preign_rd3: got %h want 00", rd_buf[3]); end
    total++; if (rd_buf[0] !== 8'h05) begin bad++; $display("FAIL preign_rd0: got %h want 05", rd_buf[0]); end
    for (int i = 0; i < D; i++) begin
      total++;
      if (rd_buf[i] !== exp_buf[i]) begin bad++; $display("FAIL preign_model[%0d]: got %h want %h", i, rd_buf[i], exp_buf[i]); end
    end
  endtask

  task automatic test_abort_arm_rst();
    int dc;
    pmode = 3; cfg(0, 0, 8'hFF, 8'hFF);
    step();
    do_arm();
    repeat (3) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    abort = 1'b1; step(); abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_wait: busy=%b done=%b want 0 0", busy, done); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL abort_trig: got %b want 0", triggered); end
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL armabort: busy=%b done=%b want 0 0", busy, done); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL armabort_hold: got %b want 0", busy); end
    // arm during POST must not restart the capture
    pmode = 0; cfg(0, 0, 8'h00, 8'h00);
    do_arm();
    repeat (4) step();
    total++; if (triggered !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL post_state: trig=%b busy=%b want 1 1", triggered, busy); end
    arm = 1'b1; step(); arm = 1'b0;
    wait_done(dc);
    total++; if (dc !== arm_cyc + 17) begin bad++; $display("FAIL post_arm_ignored: got %0d want %0d", dc, arm_cyc + 17); end
    do_arm();
    repeat (4) step();
    abort = 1'b1; step(); abort = 1'b0;
    total++; if (triggered !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL abort_post: trig=%b busy=%b want 1 0", triggered, busy); end
    do_arm();
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (triggered !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_post: trig=%b done=%b busy=%b want 0 0 0", triggered, done, busy);
    end
  endtask

  task automatic test_clamp();
    int dc;
    pmode = 0; cfg(0, 15, 8'hFF, 8'h40);
    step();
    while (probe_in !== 8'h20) step();
    do_arm();
    wait_done(dc);
    model(arm_cyc, 0, 15, 8'hFF, 8'h40);
    total++; if (dc < 0 || dc !== exp_cf + 1) begin bad++; $display("FAIL clamp_done_cyc: got %0d want %0d", dc, exp_cf + 1); end
    total++; if (plog[exp_cf-2] !== 8'h40) begin bad++; $display("FAIL clamp_last_is_trig: got %h want 40", plog[exp_cf-2]); end
    readback();
    total++; if (rd_buf[15] !== 8'h40) begin bad++; $display("FAIL clamp_rd15: got %h want 40", rd_buf[15]); end
    total++; if (rd_buf[0] !== 8'h31) begin bad++; $display("FAIL clamp_rd0: got %h want 31", rd_buf[0]); end
  endtask

  task automatic test_random();
    int dc, d, pt;
    logic [7:0] m, v;
    for (int it = 0; it < 8; it++) begin
      d  = int'($urandom_range(0, 3));
      pt = int'($urandom_range(0, 15));
      m  = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
      v  = 8'($urandom);
      pmode = 1; cfg(d, pt, m, v);
      step();
      do_arm();
      wait_done(dc);
      model(arm_cyc, d, pt, m, v);
      total++; if (dc < 0 || dc !== exp_cf + 1) begin bad++; $display("FAIL rand%0d_done_cyc: got %0d want %0d", it, dc, exp_cf + 1); end
      total++; if (triggered !== 1'b1) begin bad++; $display("FAIL rand%0d_trig: got %b want 1", it, triggered); end
      readback();
      for (int i = 0; i < D; i++) begin
        total++;
        if (rd_buf[i] !== exp_buf[i]) begin bad++; $display("FAIL rand%0d_rd[%0d]: got %h want %h", it, i, rd_buf[i], exp_buf[i]); end
      end
    end
  endtask

  initial begin
    probe_in = 8'h00; plog[0] = 8'h00;
    rst = 1'b1; arm = 1'b0; abort = 1'b0;
    test_reset();
    test_free_run();
    test_pretrig_wrap();
    test_divider();
    test_pre_ignored();
    test_abort_arm_rst();
    test_clamp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- 8-bit logic-analyzer capture engine clocked from the 135 MHz PLL output (27 MHz ×5); the direct consumer of that clock.
- Samples probe pins at a programmable rate into a circular on-chip buffer.
- Triggers on a masked pattern match and keeps a programmable number of pre-trigger samples.
- Presents a linear, oldest-first readout port to the host/UART side.

Parameters:
- DEPTH_LOG2, 10, log2 of buffer depth in samples (DEPTH = 2**DEPTH_LOG2).
- DIV_W, 16, width of the sample-rate divider.

Ports:
- clk  in  1  PLL output clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- probe_in  in  8  asynchronous probe pins.
- arm  in  1  one-cycle pulse; starts a capture.
- abort  in  1  one-cycle pulse; returns to IDLE.
- div  in  DIV_W  sample period minus 1, in clk cycles.
- trig_mask  in  8  1 = bit participates in the trigger compare.
- trig_value  in  8  required value of the masked bits.
- pretrig  in  DEPTH_LOG2  number of samples to keep before the trigger.
- rd_addr  in  DEPTH_LOG2  readout index; 0 = oldest sample.
- rd_data  out  8  buffer data for rd_addr.
- busy  out  1  state is PRE, WAIT_TRIG or POST.
- triggered  out  1  trigger has occurred in the current/last capture.
- done  out  1  state is DONE.

Behaviour:
- Input sync: probe_in passes through a 2-FF synchronizer; "sample" means the synchronizer output.
- Reset values:
  - state = IDLE; busy, triggered, done = 0; rd_data = 0.
  - wr_ptr, start_ptr, divider counter and sample counters = 0.
  - Buffer contents are not reset.
- Sample tick:
  - Counter runs 0..div and wraps to 0; tick is asserted in the cycle where count == div.
  - div = 0 gives a tick every clk.
  - Counter is cleared on arm, abort and rst.
- Effective pretrig: pt = min(pretrig, DEPTH-1).
- State machine:
  - IDLE/DONE:
    - arm clears wr_ptr, the divider counter and triggered.
    - Goes to PRE if pt > 0, otherwise to WAIT_TRIG.
  - PRE:
    - Each tick writes mem[wr_ptr] = sample, wr_ptr++, pre_cnt++.
    - The trigger is ignored in PRE.
    - After the tick that makes pre_cnt == pt, go to WAIT_TRIG.
  - WAIT_TRIG:
    - Each tick writes the sample and increments wr_ptr, wrapping modulo DEPTH.
    - If (sample & trig_mask) == (trig_value & trig_mask), that same sample is the trigger sample.
    - On trigger: set triggered = 1, start_ptr = wr_ptr - pt (mod DEPTH), post_cnt = DEPTH - pt - 1.
    - If post_cnt == 0, go to DONE; otherwise go to POST.
    - trig_mask = 0 triggers on the first tick in WAIT_TRIG.
  - POST:
    - Each tick writes the sample, wr_ptr++, post_cnt--.
    - After the tick on which post_cnt reaches 0, go to DONE.
    - Result: exactly DEPTH - pt samples written from the trigger onward, trigger sample included.
  - DONE: holds; done = 1.
- Arm/abort priority:
  - arm while busy is ignored.
  - abort in any state goes to IDLE next cycle, leaving triggered unchanged; abort beats a simultaneous arm.
- Buffer write: the write uses the sample present on the tick cycle; there is a single write port.
- Readout:
  - rd_data = mem[(start_ptr + rd_addr) mod DEPTH], registered, with 1-cycle latency.
  - Valid in any state; meaningful only when done = 1.
  - Trigger sample is at rd_addr = pt.
- rst mid-capture: rst overrides all and goes to IDLE next cycle.
- Buffer inference: must infer block RAM (synchronous read, no read-during-write bypass required).

Test Plan:
- Bench setup: DEPTH_LOG2 = 4 (DEPTH 16), DIV_W = 16.
- Free-running trigger: div=0, mask=0x00, pretrig=0, probe increments 0x00,0x01,... each clk; arm.
  - done asserts after 16 ticks.
  - rd_addr 0..15 returns 16 consecutive values beginning at the first post-arm synchronized sample.
  - triggered = 1.
- Pre-trigger wrap: div=0, pretrig=5, mask=0xFF, value=0x20, counting probe; arm.
  - rd_addr 5 = 0x20; rd_addr 0 = 0x1B; rd_addr 15 = 0x2A.
- Divider: div=3 with a counting probe.
  - Consecutive stored samples differ by 4.
  - busy lasts 16×4 clks (±sync latency) with mask=0.
- Trigger during PRE ignored: pretrig=4, value present during the first 4 ticks and again later.
  - Trigger sample is the later occurrence; rd_addr 4 holds it.
- Abort/arm/rst:
  - abort in WAIT_TRIG gives busy=0, done=0 next cycle.
  - arm+abort in the same cycle stays IDLE.
  - arm while in POST is ignored.
  - rst asserted mid-POST clears triggered and done next cycle.
- Clamp: pretrig=15 (DEPTH-1).
  - Trigger at value 0x40 gives done on the trigger tick (post_cnt = 0); rd_addr 15 = 0x40, rd_addr 0 = 0x31.
